// File: rtl/sequence_pattern_tx.sv
// sequence_pattern_tx: serial pattern transmitter feeding the Mealy sequence detectors.
// Loads a WIDTH-bit pattern and a repeat count, then streams the pattern MSB-first,
// one bit per clock, (repeat+1) times with no gaps, and pulses done after the last bit.
// Optional build macro SEQ_TX_MARKER_EN: prefixes every pattern instance with the
// 4-bit sync marker 1,0,1,0 (MARK state). When undefined, MARK is not compiled.
// Every output comes straight from a flop; the next-cycle output values are
// computed alongside the next state.
module sequence_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [REP_W-1:0] repeat_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             bit_valid_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SEQ_TX_MARKER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd2, DONE = 2'd3} state_t;
`endif

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [WIDTH-1:0] saved_q, saved_nxt;
    logic [REP_W-1:0] rep_q, rep_nxt;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_nxt;
`ifdef SEQ_TX_MARKER_EN
    logic [1:0]       mark_cnt_q, mark_cnt_nxt;
`endif
    logic             ready_nxt, data_nxt, valid_nxt, busy_nxt, done_nxt;

    // Next-state, datapath and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt    = state_q;
        shift_nxt    = shift_q;
        saved_nxt    = saved_q;
        rep_nxt      = rep_q;
        bit_cnt_nxt  = bit_cnt_q;
`ifdef SEQ_TX_MARKER_EN
        mark_cnt_nxt = mark_cnt_q;
`endif
        ready_nxt    = 1'b0;
        data_nxt     = 1'b0;
        valid_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_in) begin
                    shift_nxt   = pattern_in;
                    saved_nxt   = pattern_in;
                    rep_nxt     = repeat_in;
                    bit_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    valid_nxt   = 1'b1;
`ifdef SEQ_TX_MARKER_EN
                    state_nxt    = MARK;
                    mark_cnt_nxt = 2'd0;
                    data_nxt     = 1'b1;  // first marker bit
`else
                    state_nxt    = SHIFT;
                    data_nxt     = pattern_in[WIDTH-1];
`endif
                end else begin
                    ready_nxt = 1'b1;
                end
            end

`ifdef SEQ_TX_MARKER_EN
            MARK: begin
                busy_nxt  = 1'b1;
                valid_nxt = 1'b1;
                if (mark_cnt_q == 2'd3) begin
                    // Marker finished; the pattern is already waiting in shift_q.
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                    data_nxt    = shift_q[WIDTH-1];
                end else begin
                    // Marker is 1,0,1,0: bit i is 1 for even i, so the next bit is mark_cnt_q[0].
                    mark_cnt_nxt = mark_cnt_q + 2'd1;
                    data_nxt     = mark_cnt_q[0];
                end
            end
`endif

            SHIFT: begin
                busy_nxt = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (rep_q != '0) begin
                        rep_nxt     = rep_q - REP_W'(1);
                        shift_nxt   = saved_q;
                        bit_cnt_nxt = '0;
                        valid_nxt   = 1'b1;
`ifdef SEQ_TX_MARKER_EN
                        state_nxt    = MARK;
                        mark_cnt_nxt = 2'd0;
                        data_nxt     = 1'b1;
`else
                        data_nxt     = saved_q[WIDTH-1];
`endif
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    // Rotate rather than zero-fill; the wrapped bit is never sent because
                    // the register is reloaded from saved_q before every repetition.
                    shift_nxt   = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
                    bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
                    valid_nxt   = 1'b1;
                    data_nxt    = shift_q[WIDTH-2];
                end
            end

            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end

            default: begin
                // Unreachable encoding: recover to IDLE with reset outputs.
                state_nxt   = IDLE;
                shift_nxt   = '0;
                saved_nxt   = '0;
                rep_nxt     = '0;
                bit_cnt_nxt = '0;
                ready_nxt   = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            saved_q       <= '0;
            rep_q         <= '0;
            bit_cnt_q     <= '0;
`ifdef SEQ_TX_MARKER_EN
            mark_cnt_q    <= 2'd0;
`endif
            ready_out     <= 1'b1;
            data_out      <= 1'b0;
            bit_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q       <= state_nxt;
            shift_q       <= shift_nxt;
            saved_q       <= saved_nxt;
            rep_q         <= rep_nxt;
            bit_cnt_q     <= bit_cnt_nxt;
`ifdef SEQ_TX_MARKER_EN
            mark_cnt_q    <= mark_cnt_nxt;
`endif
            ready_out     <= ready_nxt;
            data_out      <= data_nxt;
            bit_valid_out <= valid_nxt;
            busy_out      <= busy_nxt;
            done_out      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sequence_pattern_tx.sv
// tb_sequence_pattern_tx: directed plus randomized jobs for sequence_pattern_tx.
// The reference model expands each job into its expected bit stream (optional
// marker, then pattern bits MSB-first, repeated rep+1 times) and the bench
// walks that stream cycle by cycle.
module tb_sequence_pattern_tx;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             reset_ah_in;
    logic             load_in;
    logic [WIDTH-1:0] pattern_in;
    logic [REP_W-1:0] repeat_in;
    logic             ready_out, data_out, bit_valid_out, busy_out, done_out;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_q[$];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    sequence_pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk          (clk),
        .reset_ah_in  (reset_ah_in),
        .load_in      (load_in),
        .pattern_in   (pattern_in),
        .repeat_in    (repeat_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .bit_valid_out(bit_valid_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"}, ready_out, 1'b1);
        check({tag, ".data"}, data_out, 1'b0);
        check({tag, ".valid"}, bit_valid_out, 1'b0);
        check({tag, ".busy"}, busy_out, 1'b0);
        check({tag, ".done"}, done_out, 1'b0);
    endtask

    // Reference model: the full stream a job must produce.
    function automatic void build_stream(input logic [WIDTH-1:0] pat, input int rep);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
`ifdef SEQ_TX_MARKER_EN
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
`endif
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(pat[i]);
        end
    endfunction

    // One job: load, walk the expected stream, then the done cycle and the idle cycle.
    // inject_at >= 0 pulses a competing load during that stream bit.
    task automatic run_job(input logic [WIDTH-1:0] pat, input logic [REP_W-1:0] rep,
                           input int inject_at);
        for (int t = 0; t < 50 && ready_out !== 1'b1; t++) tick();
        check("ready_before_load", ready_out, 1'b1);
        build_stream(pat, int'(rep));
        pattern_in = pat;
        repeat_in  = rep;
        load_in    = 1'b1;
        tick();
        load_in    = 1'b0;
        pattern_in = WIDTH'($urandom);
        repeat_in  = REP_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            check("stream.valid", bit_valid_out, 1'b1);
            check("stream.data", data_out, exp_q[i]);
            check("stream.ready", ready_out, 1'b0);
            check("stream.busy", busy_out, 1'b1);
            check("stream.done", done_out, 1'b0);
            if (i == inject_at) begin
                load_in    = 1'b1;
                pattern_in = '1;
                repeat_in  = '1;
            end
            tick();
            load_in = 1'b0;
        end
        check("done.done", done_out, 1'b1);
        check("done.valid", bit_valid_out, 1'b0);
        check("done.data", data_out, 1'b0);
        check("done.busy", busy_out, 1'b1);
        check("done.ready", ready_out, 1'b0);
        tick();
        check_idle("after_done");
    endtask

    initial begin
        reset_ah_in = 1'b1;
        load_in     = 1'b0;
        pattern_in  = '0;
        repeat_in   = '0;
        #2;
        check_idle("reset_no_edge");
        tick();
        tick();
        reset_ah_in = 1'b0;
        tick();
        check_idle("idle_no_load");
        tick();
        check_idle("idle_still");

        // Basic single transmission and repeated transmission.
        run_job(8'hA5, 4'd0, -1);
        run_job(8'h0F, 4'd2, -1);

        // Load during busy must be ignored.
        run_job(8'h3C, 4'd0, 2);

        // Reset mid-stream: immediate idle outputs, no done pulse afterwards.
        pattern_in = 8'hFF;
        repeat_in  = 4'd0;
        load_in    = 1'b1;
        tick();
        load_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort.valid", bit_valid_out, 1'b1);
            check("abort.data", data_out, 1'b1);
            if (i < 2) tick();
        end
        #2;
        reset_ah_in = 1'b1;
        #1;
        check_idle("abort_reset_immediate");
        tick();
        check_idle("abort_reset_held");
        reset_ah_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("abort_no_done");
        end
        run_job(8'h81, 4'd0, -1);

        // Maximum repeat count: 2^REP_W transmissions, no wrap.
        run_job(8'h5A, 4'hF, -1);

        // Randomized jobs, some with a competing load mid-stream.
        for (int j = 0; j < 20; j++) begin
            run_job(WIDTH'($urandom), REP_W'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sequence_pattern_tx.md
Name: sequence_pattern_tx

Overview:
Serial pattern transmitter. It produces the bit streams that the team's Mealy sequence detectors consume.
- Accepts a WIDTH-bit pattern word and a repeat count through a load handshake.
- Shifts the pattern out MSB-first, one bit per clock, with a bit-valid strobe.
- Pulses done when the final bit has been sent.
- Acts as the stimulus/driver end of the serial data_in line for detector blocks.

Parameters:
WIDTH, 8, pattern word length in bits (>=2)
REP_W, 4, width of repeat count field

Ports:
clk  input  1  system clock, rising edge
reset_ah_in  input  1  asynchronous reset, active-high
load_in  input  1  load request, sampled on rising clk when ready_out=1
pattern_in  input  WIDTH  pattern word, captured with load_in
repeat_in  input  REP_W  extra repetitions; total transmissions = repeat_in+1
ready_out  output  1  block idle, load accepted this cycle
data_out  output  1  serial bit, valid when bit_valid_out=1, else 0
bit_valid_out  output  1  data_out carries a pattern/marker bit
busy_out  output  1  transmission in progress (any state except IDLE)
done_out  output  1  single-cycle pulse after last bit of last repetition

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE; shift register, saved pattern and all counters = 0.
  - ready_out=1, data_out=0, bit_valid_out=0, busy_out=0, done_out=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, MARK (present only with the macro), SHIFT, DONE.
- IDLE:
  - ready_out=1.
  - If load_in=1 at an edge: capture pattern_in into the shift register and the saved copy; capture repeat_in into the repeat counter; clear the bit counter.
  - Go to SHIFT (or MARK when enabled).
  - If load_in=0: stay in IDLE.
- Latency: for a load accepted at edge k, the first bit is on data_out with bit_valid_out=1 during the cycle after edge k. ready_out=0 from that same cycle.
- SHIFT:
  - data_out = current MSB, bit_valid_out=1. Shift left each cycle; bit counter increments.
  - After WIDTH bits, if repeat counter != 0: decrement it, reload the shift register from the saved copy, and continue with no gap cycle (MARK first if enabled).
  - If repeat counter == 0: go to DONE.
- DONE:
  - One cycle: done_out=1, bit_valid_out=0, data_out=0, ready_out=0, busy_out=1. Then IDLE.
  - Minimum spacing between the last bit of one job and the first bit of the next is 2 cycles (DONE, IDLE-accept).
- bit_valid_out stays high continuously for (repeat_in+1)*WIDTH cycles (plus markers), with no bubbles.
- load_in while busy_out=1 is ignored. Captured values are unaffected by changes to pattern_in or repeat_in.
- repeat_in at its maximum (2^REP_W - 1) gives 2^REP_W transmissions. The counter never wraps.
- Bit counter width is clog2(WIDTH) or wider. There is no illegal-state lockup: the default branch returns to IDLE with reset output values.
- Reset asserted mid-stream aborts the transmission. No done_out pulse is generated. After release, the next load is accepted normally.

Optional Feature:
SEQ_TX_MARKER_EN
- Defined:
  - Before every pattern instance, including each repetition, the FSM enters MARK and emits the 4-bit sync marker 1,0,1,0 with bit_valid_out=1, then goes to SHIFT.
  - Each instance is 4+WIDTH bits. The stream stays gapless across marker/pattern/repeat boundaries.
  - The first marker bit appears in the cycle after load acceptance.
- Undefined: the MARK state and its counter are not compiled. Streams contain only pattern bits.

Test Plan:
1. Assert reset_ah_in mid-cycle with no clock edge -> outputs immediately ready=1, data=0, valid=0, busy=0, done=0.
2. WIDTH=8, load 0xA5, repeat=0 -> data_out 1,0,1,0,0,1,0,1 with valid for 8 cycles; done_out=1 in cycle 9; ready_out=1 in cycle 10.
3. Load 0x0F, repeat=2 -> 24 gapless valid bits (00001111 x3); exactly one done pulse, after bit 24.
4. Load 0x3C; on bit 3 pulse load_in with 0xFF -> stream stays 00111100; ready_out stays 0; the second load is not captured.
5. Load 0xFF; assert reset after 3 bits -> valid=0 and data=0 immediately; no done pulse; after release, load 0x81 -> 1,0,0,0,0,0,0,1.
6. SEQ_TX_MARKER_EN defined, load 0xA5, repeat=1 -> 1010 10100101 1010 10100101 (24 gapless bits); done in cycle 25.
